// File: rtl/i2c_reg_master_pkg.sv
// i2c_pkg: shared state encoding, R/W bit values and quarter-bit timing helper
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, BUS_FREE
  } state_t;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  function automatic int qtr_clks(input int clk_mhz, input int i2c_khz);
    return clk_mhz * 1000 / (4 * i2c_khz);
  endfunction
endpackage

// File: rtl/i2c_reg_master_if.sv
// i2c_reg_master_if: register-side command/status and open-drain pin signals
interface i2c_reg_master_if;
  logic       cmd_start;
  logic       cmd_rd;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wr_data;
  logic       cmd_busy;
  logic       done;
  logic       ack_error;
  logic [7:0] rd_data;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_in;
  logic       sda_in;
  modport master (
    input  cmd_start, cmd_rd, cmd_dev_addr, cmd_reg_addr, cmd_wr_data, scl_in, sda_in,
    output cmd_busy, done, ack_error, rd_data, scl_oe, sda_oe
  );
  modport slave (
    output cmd_start, cmd_rd, cmd_dev_addr, cmd_reg_addr, cmd_wr_data, scl_in, sda_in,
    input  cmd_busy, done, ack_error, rd_data, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_reg_master_qtr_tick.sv
// i2c_qtr_tick: quarter-bit timer with clock-stretch freeze and 0..3 phase index
module i2c_qtr_tick #(
  parameter int QTR = 65
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       stretch,
  output logic       tick,
  output logic [1:0] phase
);
  localparam int W = $clog2(QTR);
  localparam logic [W-1:0] LAST = W'(QTR - 1);
  logic [W-1:0] cnt;
  assign tick = en && !stretch && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      phase <= '0;
    end else if (!stretch) begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      phase <= tick ? phase + 2'd1 : phase;
    end
  end
endmodule

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-byte I2C register write / read (repeated START) bus master
module i2c_reg_master import i2c_pkg::*; #(
  parameter int CLK_FRQ_MHZ  = 26,
  parameter int I2C_FREQ_KHZ = 100
) (
  input logic clk,
  input logic rst,
  i2c_reg_master_if.master bus
);
  localparam int QTR = qtr_clks(CLK_FRQ_MHZ, I2C_FREQ_KHZ);
  state_t     state, state_n;
  logic       tick, accept, slot_end, smp, rw, scl_n, sda_n;
  logic [1:0] phase, byte_idx;
  logic [2:0] bit_cnt;
  logic [6:0] dev;
  logic [7:0] reg_a, wdata, rx_sh, tx_byte;
  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk(clk), .rst(rst), .en(state != IDLE),
    .stretch(!bus.scl_oe && !bus.scl_in), .tick(tick), .phase(phase)
  );
  assign accept   = state == IDLE && bus.cmd_start && !bus.cmd_busy;
  assign slot_end = tick && phase == 2'd3;
  assign tx_byte  = byte_idx == 2'd0 ? {dev, RW_WRITE} :
                    byte_idx == 2'd1 ? reg_a : rw ? {dev, RW_READ} : wdata;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Line drives are decoded from state/phase and registered below, so the bus never glitches.
  always_comb begin
    state_n = state;
    scl_n   = 1'b0;
    sda_n   = 1'b0;
    unique case (state)
      IDLE: state_n = accept ? START : IDLE;
      START: begin
        scl_n = phase == 2'd3;
        sda_n = phase != 2'd0;
        if (slot_end) state_n = TX_BYTE;
      end
      TX_BYTE: begin
        scl_n = !phase[1];
        sda_n = !tx_byte[bit_cnt];
        if (slot_end && bit_cnt == 3'd0) state_n = RX_ACK;
      end
      RX_ACK: begin
        scl_n = !phase[1];
        if (slot_end) state_n = smp ? STOP : byte_idx == 2'd0 ? TX_BYTE :
                                byte_idx == 2'd1 ? (rw ? RESTART : TX_BYTE) :
                                rw ? RX_BYTE : STOP;
      end
      RESTART: begin
        scl_n = phase == 2'd0 || phase == 2'd3;
        sda_n = phase[1];
        if (slot_end) state_n = TX_BYTE;
      end
      RX_BYTE: begin
        scl_n = !phase[1];
        if (slot_end && bit_cnt == 3'd0) state_n = TX_NACK;
      end
      TX_NACK: begin
        scl_n = !phase[1];
        if (slot_end) state_n = STOP;
      end
      STOP: begin
        scl_n = phase == 2'd0;
        sda_n = phase != 2'd3;
        if (slot_end) state_n = BUS_FREE;
      end
      BUS_FREE: if (slot_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cmd_busy  <= 1'b0;
      bus.done      <= 1'b0;
      bus.ack_error <= 1'b0;
      bus.rd_data   <= '0;
      bus.scl_oe    <= 1'b0;
      bus.sda_oe    <= 1'b0;
    end else begin
      bus.done   <= slot_end && state == BUS_FREE;
      bus.scl_oe <= scl_n;
      bus.sda_oe <= sda_n;
      if (accept) begin
        bus.cmd_busy  <= 1'b1;
        bus.ack_error <= 1'b0;
        rw            <= bus.cmd_rd;
        dev           <= bus.cmd_dev_addr;
        reg_a         <= bus.cmd_reg_addr;
        wdata         <= bus.cmd_wr_data;
        bit_cnt       <= 3'd7;
        byte_idx      <= 2'd0;
      end else if (bus.done) bus.cmd_busy <= 1'b0;
      if (tick && phase == 2'd2) smp <= bus.sda_in;
      if (slot_end && (state == TX_BYTE || state == RX_BYTE)) bit_cnt <= bit_cnt - 3'd1;
      if (slot_end && state == RX_BYTE) rx_sh <= {rx_sh[6:0], smp};
      if (slot_end && state == RX_ACK) begin
        byte_idx <= byte_idx + 2'd1;
        if (smp) bus.ack_error <= 1'b1;
      end
      if (slot_end && state == TX_NACK) bus.rd_data <= rx_sh;
    end
  end
endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed + random transactions against an I2C slave model and a transcript-level reference
module tb_i2c_reg_master;
  localparam int QTR  = 65;
  localparam int S_EV = 1024;
  localparam int P_EV = 2048;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_reg_master_if bus();
  i2c_reg_master #(.CLK_FRQ_MHZ(26), .I2C_FREQ_KHZ(100)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_asrt = 0, n_fail = 0, cyc = 0, t0 = 0, last_lat = 0, lat_w = 0, exp_lat = 0;
  int exp_q[$], got_q[$];
  bit exp_err = 1'b0;
  logic [7:0] exp_rd = 8'h00;
  logic s_sda = 1'b0, s_scl = 1'b0, pscl = 1'b1, psda = 1'b1, slave_tx = 1'b0, ackv = 1'b0, stretch_en = 1'b0;
  logic [7:0] sh = 8'h00, rv = 8'h00;
  int bitn = 0, byte_no = 0, slot = 0, nack_slot = -1, hold_cnt = 0;
  assign bus.scl_in = !(bus.scl_oe || s_scl);
  assign bus.sda_in = !(bus.sda_oe || s_sda);
  always @(posedge clk) cyc++;
  // Slave device: logs START/STOP/bytes with the ACK level, ACKs, serves read data, can stretch once.
  always @(negedge clk) begin
    logic scl, sda;
    scl = bus.scl_in;
    sda = bus.sda_in;
    if (rst) begin
      s_sda = 1'b0; s_scl = 1'b0; bitn = 0; slave_tx = 1'b0; pscl = 1'b1; psda = 1'b1;
    end else begin
      if (s_scl && !bus.scl_oe) begin
        if (hold_cnt == 500) s_scl = 1'b0;
        else hold_cnt++;
      end
      if (scl && pscl && sda != psda) begin
        got_q.push_back(sda ? P_EV : S_EV);
        if (!sda) begin bitn = 0; byte_no = 0; slave_tx = 1'b0; end
      end else if (scl && !pscl) begin
        if (bitn < 8) sh = {sh[6:0], sda};
        else begin ackv = sda; got_q.push_back(int'(sh) + (sda ? 256 : 0)); end
        bitn++;
      end else if (!scl && pscl) begin
        if (bitn == 8) begin
          s_sda = !slave_tx && slot != nack_slot;
          if (!slave_tx) slot++;
        end else if (bitn == 9) begin
          slave_tx = byte_no == 0 && sh[0] && !ackv;
          byte_no++;
          bitn = 0;
          s_sda = slave_tx && !rv[7];
        end else if (bitn > 0 && slave_tx) s_sda = !rv[7 - bitn];
        if (stretch_en && byte_no == 1 && bitn == 3 && !slave_tx) begin
          s_scl = 1'b1; hold_cnt = 0; stretch_en = 1'b0;
        end
      end
      pscl = scl;
      psda = sda;
    end
  end
  task automatic chk(input string tag, input longint got, input longint exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input longint got, input longint lo, input longint hi);
    n_asrt++;
    assert ((got >= lo && got <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask
  // Reference: bus transcript, duration in quarters, status, from the transaction rules.
  task automatic model(input bit rd, input logic [6:0] dev, input logic [7:0] rg, wd, rvv, input int nk);
    logic [7:0] tx[$];
    int q;
    bit err;
    tx.delete();
    tx.push_back({dev, 1'b0});
    tx.push_back(rg);
    tx.push_back(rd ? {dev, 1'b1} : wd);
    exp_q.delete();
    exp_q.push_back(S_EV);
    q = 4;
    err = 1'b0;
    foreach (tx[i]) if (!err) begin
      if (rd && i == 2) begin exp_q.push_back(S_EV); q += 4; end
      err = i == nk;
      exp_q.push_back(int'(tx[i]) + (err ? 256 : 0));
      q += 36;
    end
    if (rd && !err) begin exp_q.push_back(int'(rvv) + 256); q += 36; exp_rd = rvv; end
    exp_q.push_back(P_EV);
    q += 8;
    exp_lat = q * QTR;
    exp_err = err;
  endtask
  task automatic run(input bit rd, input logic [6:0] dev, input logic [7:0] rg, wd, rvv,
                     input int nk, input int mid, input bit dn, input int extra);
    int k;
    bit seen;
    model(rd, dev, rg, wd, rvv, nk);
    got_q.delete();
    slot = 0;
    nack_slot = nk;
    rv = rvv;
    @(negedge clk);
    bus.cmd_rd = rd; bus.cmd_dev_addr = dev; bus.cmd_reg_addr = rg; bus.cmd_wr_data = wd;
    bus.cmd_start = 1'b1;
    t0 = cyc + 1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 30000) begin
      @(negedge clk);
      k++;
      bus.cmd_start = mid > 0 && k == mid;
      if (bus.cmd_start) begin bus.cmd_rd = ~rd; bus.cmd_dev_addr = 7'h55; bus.cmd_wr_data = 8'hFF; end
      seen = bus.done;
    end
    last_lat = cyc - t0;
    chk("done_seen", seen, 1);
    bus.cmd_start = dn && seen;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    chk("done_pulse_width", bus.done, 0);
    chk("busy_after_done", bus.cmd_busy, 0);
    chk_rng("latency", last_lat, exp_lat + extra - 2, exp_lat + extra + 2);
    chk("ack_error", bus.ack_error, exp_err);
    chk("rd_data", bus.rd_data, exp_rd);
    repeat (300) @(negedge clk);
    chk("busy_idle", bus.cmd_busy, 0);
    chk("bus_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("bus_ev%0d", i), got_q[i], exp_q[i]);
  endtask
  initial begin
    int k;
    bit seen;
    bus.cmd_start = 1'b0; bus.cmd_rd = 1'b0; bus.cmd_dev_addr = '0; bus.cmd_reg_addr = '0; bus.cmd_wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.cmd_busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_error", bus.ack_error, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_scl_oe", bus.scl_oe, 0);
    chk("rst_sda_oe", bus.sda_oe, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run(1'b0, 7'h1D, 8'h2A, 8'h01, 8'h00, -1, 0, 1'b0, 0);
    lat_w = last_lat;
    run(1'b1, 7'h1D, 8'h0D, 8'h00, 8'h4A, -1, 0, 1'b0, 0);
    run(1'b1, 7'h1D, 8'h0D, 8'h00, 8'h55, 0, 0, 1'b0, 0);
    stretch_en = 1'b1;
    run(1'b0, 7'h1D, 8'h2A, 8'h01, 8'h00, -1, 0, 1'b0, 500);
    chk("stretch_delta", last_lat - lat_w, 500);
    run(1'b0, 7'h1D, 8'h2A, 8'h01, 8'h00, -1, 3000, 1'b1, 0);
    got_q.delete();
    slot = 0;
    nack_slot = -1;
    rv = 8'hC3;
    @(negedge clk);
    bus.cmd_rd = 1'b1; bus.cmd_dev_addr = 7'h1D; bus.cmd_reg_addr = 8'h0D; bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    k = 0;
    while (!(slave_tx && bitn == 4) && k < 20000) begin @(negedge clk); k++; end
    chk("reached_rx_bit4", slave_tx && bitn == 4, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_scl_oe", bus.scl_oe, 0);
    chk("mid_rst_sda_oe", bus.sda_oe, 0);
    chk("mid_rst_busy", bus.cmd_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_rd = 8'h00;
    seen = 1'b0;
    repeat (2000) begin @(negedge clk); seen = seen | bus.done; end
    chk("mid_rst_no_done", seen, 0);
    for (int r = 0; r < 2; r++) begin
      int nk;
      nk = $urandom_range(0, 5);
      run(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          nk > 2 ? -1 : nk, 0, 1'b0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- I2C initiator for the CPU_I2C0 bus. The existing MCU interface is the I2C responder on I2C1; this block is the bus master.
- Performs single-byte register write and register read (write-pointer, repeated START, read) transactions to one external 7-bit-addressed device.
- Commands come from the REGISTERS block. Read data and status return to REGISTERS, and completion can raise irq.
- Drives open-drain SCL/SDA through output-enable signals: oe=1 pulls the line low, oe=0 releases it.

Parameters:
- CLK_FRQ_MHZ, 26, system clock frequency in MHz.
- I2C_FREQ_KHZ, 100, SCL frequency in kHz.
- QTR (derived localparam), CLK_FRQ_MHZ*1000/(4*I2C_FREQ_KHZ) = 65, clocks per quarter-bit.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- cmd_start  in  1  one-clock pulse that launches a transaction. Ignored while cmd_busy=1.
- cmd_rd  in  1  1 = register read, 0 = register write. Sampled with cmd_start.
- cmd_dev_addr  in  7  device address. Sampled with cmd_start.
- cmd_reg_addr  in  8  register pointer. Sampled with cmd_start.
- cmd_wr_data  in  8  write data. Sampled with cmd_start.
- cmd_busy  out  1  high from the clock after an accepted cmd_start until the clock done pulses.
- done  out  1  one-clock pulse at transaction end.
- ack_error  out  1  valid with done; 1 = a NACK was received. Held until the next accepted cmd_start.
- rd_data  out  8  read byte. Updated only on a successful read; held otherwise.
- scl_oe  out  1  1 = drive SCL low.
- sda_oe  out  1  1 = drive SDA low.
- scl_in  in  1  synchronized SCL pin level.
- sda_in  in  1  synchronized SDA pin level.

Behaviour:
- Reset values: cmd_busy=0, done=0, ack_error=0, rd_data=0, scl_oe=0, sda_oe=0. State goes to IDLE and the quarter counter is cleared.
- Reset mid-transaction: both lines are released on the clock after rst. No STOP is generated and no done pulse is issued.
- Quarter tick: the counter runs 0..QTR-1 and ticks at QTR-1. It is frozen while SCL is released but scl_in=0 (clock stretching). There is no stretch timeout.
- Bit slot = 4 quarters:
  - q0: SCL low; SDA updated at q0 entry.
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL high; SDA sampled at q3 entry.
  - SDA never changes while SCL is high, except in START/RESTART/STOP.
- States:
  - IDLE: on accepted cmd_start, latch the inputs, set cmd_busy, clear ack_error, go to START.
  - START (4q): SDA falls while SCL is high, then SCL goes low.
  - TX_BYTE (8 bits, MSB first) then RX_ACK (1 bit). SDA=1 at the ACK sample is a NACK: set ack_error and go to STOP.
  - Byte sequence for a write: {dev,0}, reg, wr_data, then STOP.
  - Byte sequence for a read: {dev,0}, reg, then RESTART (4q: release SDA, raise SCL, pull SDA low), then {dev,1}, then RX_BYTE.
  - RX_BYTE (8 bits, MSB first, SDA released) then TX_NACK (1 bit, SDA released). After TX_NACK, load rd_data and go to STOP.
  - STOP (4q): SDA low, SCL high, SDA released.
  - BUS_FREE (4q): both lines released. Then pulse done, drop cmd_busy, return to IDLE.
- Nominal latency, cmd_start to done with QTR=65 and no stretching:
  - Write: (4+108+4+4)*QTR = 120q = 7800 clocks, tolerance ±2.
  - Read: (4+72+4+72+4+4)*QTR = 160q = 10400 clocks, tolerance ±2.
- NACK on any ACK slot: STOP is issued immediately after that slot. rd_data is unchanged.
- cmd_start in the same clock as done: ignored, because cmd_busy is still 1 that clock.
- No multi-master arbitration. sda_in is not compared against the driven value.

Decomposition:
- Shared package i2c_pkg:
  - state encoding localparams: IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, BUS_FREE;
  - RW_WRITE=0, RW_READ=1;
  - the QTR formula.
- Sub-module i2c_qtr_tick: quarter counter with stretch freeze, phase index 0..3, and tick output.

Test Plan:
- Write: cmd_start, cmd_rd=0, dev=0x1D, reg=0x2A, data=0x01, slave model ACKs all → bus bytes 0x3A,0x2A,0x01; done at 7800±2 clocks; ack_error=0.
- Read: dev=0x1D, reg=0x0D, slave returns 0x4A → bytes 0x3A,0x0D, RESTART, 0x3B; master NACKs the data byte; rd_data=0x4A; done at 10400±2; ack_error=0.
- Address NACK: slave NACKs 0x3A → STOP follows the first ACK slot; done pulses; ack_error=1; rd_data keeps its prior value 0x4A.
- Stretch: slave holds SCL low 500 clocks in bit 3 of the reg byte → done is exactly 500 clocks later than nominal; no SDA change while SCL is high.
- Reset mid-read: assert rst during RX_BYTE bit 4 → next clock scl_oe=0, sda_oe=0, cmd_busy=0; no done pulse.
- Busy guard: second cmd_start pulsed during a write, and another in the done cycle → both ignored; exactly one transaction appears on the bus.
